// File: rtl/pio_gen_pkg.sv
// Shared definitions for the parametrised Avalon-MM PIO block.
package pio_gen_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // Priming spans the 2-flop synchroniser fill plus the load cycle, so
    // the filter is seeded from a real input sample, never the reset zeros.
    localparam int PRIME_CYCLES = 3;

    // Debounce counter width; at least one bit so the bypass build stays legal.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit debounce filter: the filtered value follows the synchronised
// input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce_bit
    import pio_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic prime,
    input  logic d_sync,
    output logic q_filt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Next-state: load directly while priming or bypassed, else count stability.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (prime || DEBOUNCE_CYCLES == 0) begin
            filt_d = d_sync;
        end else if (d_sync != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = d_sync;
            else                                  cnt_d  = cnt_q + 1'b1;
        end
    end

    // Counter and filtered-value registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign q_filt = filt_q;

endmodule

// File: rtl/avalon_pio_gen.sv
// Parametrised Avalon-MM PIO: synchronised/debounced inputs with edge capture
// and a maskable level IRQ, plus direction and set/clear output registers.
module avalon_pio_gen
    import pio_gen_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in_port,
    output logic [WIDTH-1:0] pio_out_port,
    output logic [WIDTH-1:0] pio_oe
);

    localparam logic [1:0] EM = EDGE_MODE[1:0];

    logic [WIDTH-1:0] s1_q, sync_q, filt, filt_dly_q;
    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d, ecap_clr, edge_w, wd;
    logic [1:0]       pcnt_q;
    logic             primed_q, prime, irq_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_ok;

    assign wd        = avs_writedata[WIDTH-1:0];
    assign unused_ok = &{1'b0, avs_writedata};
    assign prime     = ~primed_q;

    // Synchroniser, filter delay line and post-reset priming sequencer.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_q       <= '0;
            sync_q     <= '0;
            filt_dly_q <= '0;
            pcnt_q     <= '0;
            primed_q   <= 1'b0;
        end else begin
            s1_q       <= pio_in_port;
            sync_q     <= s1_q;
            filt_dly_q <= prime ? sync_q : filt;
            if (!primed_q) begin
                pcnt_q <= pcnt_q + 2'd1;
                if (pcnt_q == 2'(PRIME_CYCLES - 1)) primed_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .prime         (prime),
            .d_sync        (sync_q[i]),
            .q_filt        (filt[i])
        );
    end

    // Edge select per EDGE_MODE, suppressed until priming completes.
    always_comb begin
        edge_w = '0;
        case (edge_mode_e'(EM))
            EDGE_RISE: edge_w = filt & ~filt_dly_q;
            EDGE_FALL: edge_w = ~filt & filt_dly_q;
            default:   edge_w = filt ^ filt_dly_q;
        endcase
        if (!primed_q) edge_w = '0;
    end

    // Register writes; a capture in the same cycle as a clear wins.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        mask_d   = mask_q;
        ecap_clr = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA:    out_d    = wd;
                ADDR_DIR:     dir_d    = wd;
                ADDR_IRQMASK: mask_d   = wd;
                ADDR_EDGECAP: ecap_clr = wd;
                ADDR_OUTSET:  out_d    = out_q | wd;
                ADDR_OUTCLR:  out_d    = out_q & ~wd;
                default:      ;
            endcase
        end
        ecap_d = (ecap_q & ~ecap_clr) | edge_w;
    end

    // Read mux from pre-write state; unused upper bits stay zero.
    always_comb begin
        rdata_d = '0;
        case (avs_address)
            ADDR_DATA:    rdata_d[WIDTH-1:0] = (dir_q & out_q) | (~dir_q & filt);
            ADDR_DIR:     rdata_d[WIDTH-1:0] = dir_q;
            ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rdata_d[WIDTH-1:0] = ecap_q;
            default:      rdata_d = '0;
        endcase
    end

    // Control/status registers, registered read data and IRQ.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_q   <= RESET_OUT;
            dir_q   <= '0;
            mask_q  <= '0;
            ecap_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            ecap_q <= ecap_d;
            irq_q  <= |(ecap_q & mask_q);
            if (avs_read) rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign pio_out_port = out_q;
    assign pio_oe       = dir_q;

endmodule
